// File: rtl/axis_pkg.sv
// axis_pkg: shared widths and arbiter state type for the AXIS client arbiter.
package axis_pkg;
  localparam int DATAW = 128;
  localparam int DESTW = 4;
  localparam int IDW   = 32;
  localparam int USERW = 66;
  localparam int STRBW = 8;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/axis_client_arbiter_if.sv
// axis_client_arbiter_if: requester-side streams plus the shared NoC AXIS port.
interface axis_client_arbiter_if #(parameter int NUM_REQ = 4);
  import axis_pkg::*;
  logic [NUM_REQ-1:0]       req_tvalid;
  logic [NUM_REQ-1:0]       req_tlast;
  logic [NUM_REQ*DATAW-1:0] req_tdata;
  logic [NUM_REQ*DESTW-1:0] req_tdest;
  logic [NUM_REQ-1:0]       req_tready;
  logic                     axis_tready;
  logic                     axis_tvalid;
  logic                     axis_tlast;
  logic [DATAW-1:0]         axis_tdata;
  logic [DESTW-1:0]         axis_tdest;
  logic [IDW-1:0]           axis_tid;
  logic [STRBW-1:0]         axis_tstrb;
  logic [STRBW-1:0]         axis_tkeep;
  logic [USERW-1:0]         axis_tuser;
  modport master (
    input  req_tvalid, req_tlast, req_tdata, req_tdest, axis_tready,
    output req_tready, axis_tvalid, axis_tlast, axis_tdata, axis_tdest,
           axis_tid, axis_tstrb, axis_tkeep, axis_tuser
  );
  modport slave (
    output req_tvalid, req_tlast, req_tdata, req_tdest, axis_tready,
    input  req_tready, axis_tvalid, axis_tlast, axis_tdata, axis_tdest,
           axis_tid, axis_tstrb, axis_tkeep, axis_tuser
  );
endinterface

// File: rtl/axis_client_arbiter_rr_pick.sv
// rr_pick: combinational round-robin encoder; first request after ptr wins.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   idx
);
  int best, d;
  assign valid = |req;
  // d is the distance of requester i past ptr, so ptr+1 has distance 0
  always_comb begin
    idx = '0;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - 1 - int'(ptr)) % N;
      if (req[i] && d < best) begin
        best = d;
        idx = 3'(i);
      end
    end
  end
endmodule

// File: rtl/axis_client_arbiter.sv
// axis_client_arbiter: packet-granular round-robin share of one NoC AXIS port.
// Define AXIS_ARB_PKT_CNT_EN to add per-requester packet and total beat counters.
module axis_client_arbiter
  import axis_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter logic [USERW-1:0] SRC_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_client_arbiter_if.master    bus,
  output logic [2:0]               grant_idx,
  output logic                     busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]    pkt_count,
  output logic [31:0]              beat_count
`endif
);
  arb_state_t state, state_nxt;
  logic [2:0] rr_ptr, pick_idx;
  logic       pick_valid, fire, done;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (bus.req_tvalid),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= 3'(NUM_REQ - 1);
      grant_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) grant_idx <= pick_idx;
      if (done) rr_ptr <= grant_idx;
    end
  // the granted slice drives the NoC port combinationally, no beat latency
  always_comb begin
    busy = state == LOCKED;
    bus.axis_tvalid = 1'b0;
    bus.axis_tlast = 1'b0;
    bus.axis_tdata = '0;
    bus.axis_tdest = '0;
    bus.req_tready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_idx == 3'(i)) begin
        bus.axis_tvalid = busy && bus.req_tvalid[i];
        bus.axis_tlast = bus.req_tlast[i];
        bus.axis_tdata = bus.req_tdata[i*DATAW +: DATAW];
        bus.axis_tdest = bus.req_tdest[i*DESTW +: DESTW];
        bus.req_tready[i] = busy && bus.axis_tready;
      end
    fire = bus.axis_tvalid && bus.axis_tready;
    done = fire && bus.axis_tlast;
    state_nxt = state == IDLE ? (pick_valid ? LOCKED : IDLE) : (done ? IDLE : LOCKED);
  end
  assign bus.axis_tid   = IDW'(grant_idx);
  assign bus.axis_tstrb = '0;
  assign bus.axis_tkeep = '0;
  assign bus.axis_tuser = SRC_ADDR;
`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pkt_count  <= '0;
      beat_count <= '0;
    end else begin
      if (fire) beat_count <= beat_count + 32'd1;
      for (int i = 0; i < NUM_REQ; i++)
        if (done && grant_idx == 3'(i)) pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_axis_client_arbiter.sv
// tb_axis_client_arbiter: directed vectors for reset, round robin, stalls, grant hold, tags, async reset.
module tb_axis_client_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] grant_idx;
  logic       busy;
  int         n_vec = 0;
  int         n_err = 0;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [63:0] pkt_count;
  logic [31:0] beat_count;
`endif
  axis_client_arbiter_if #(.NUM_REQ(4)) bus ();
  axis_client_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_idx(grant_idx),
    .busy     (busy)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_count (pkt_count),
    .beat_count(beat_count)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int p, ph, g;
  logic [127:0] dd[5];
  logic         tr[5];
  logic         lst[5];

  initial begin
    rst = 1'b0;
    bus.req_tvalid = '1;
    bus.req_tlast = '1;
    bus.req_tdata = '0;
    bus.req_tdest = '0;
    bus.axis_tready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_tvalid", bus.axis_tvalid, 0);
    chk("rst_tready", bus.req_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    // round robin: 2-beat packets from everyone, bubble between packets
    for (int k = 0; k < 15; k++) begin
      p = k / 3;
      ph = k % 3;
      g = p % 4;
      bus.req_tvalid = '1;
      bus.req_tlast = ph == 2 ? 4'(1 << g) : 4'b0;
      for (int i = 0; i < 4; i++) bus.req_tdata[i*128 +: 128] = 128'(p * 256 + i * 16 + ph);
      #1;
      if (ph == 0) begin
        chk("rr_bubble_tvalid", bus.axis_tvalid, 0);
        chk("rr_bubble_tready", bus.req_tready, 0);
      end else begin
        chk("rr_grant", grant_idx, 128'(g));
        chk("rr_tid", bus.axis_tid, 128'(g));
        chk("rr_tvalid", bus.axis_tvalid, 1);
        chk("rr_tlast", bus.axis_tlast, 128'(ph == 2));
        chk("rr_tdata", bus.axis_tdata, 128'(p * 256 + g * 16 + ph));
        chk("rr_tready", bus.req_tready, 128'(1 << g));
      end
      @(negedge clk);
    end
    // backpressure on a 3-beat packet from requester 2
    dd = '{128'hA, 128'hB, 128'hB, 128'hB, 128'hC};
    tr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req_tvalid = 4'b0100;
    bus.req_tlast = '0;
    bus.req_tdata[2*128 +: 128] = 128'hA;
    bus.axis_tready = 1'b1;
    #1;
    chk("bp_bubble", bus.axis_tvalid, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.axis_tready = tr[c];
      bus.req_tdata[2*128 +: 128] = dd[c];
      bus.req_tlast = {1'b0, lst[c], 2'b00};
      #1;
      chk("bp_grant", grant_idx, 2);
      chk("bp_tvalid", bus.axis_tvalid, 1);
      chk("bp_tdata", bus.axis_tdata, dd[c]);
      chk("bp_tlast", bus.axis_tlast, 128'(lst[c]));
      chk("bp_tready", bus.req_tready, tr[c] ? 128'h4 : 128'h0);
      @(negedge clk);
    end
    bus.req_tvalid = '0;
    bus.axis_tready = 1'b1;
    #1;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_tvalid", bus.axis_tvalid, 0);
    @(negedge clk);
    // requester 1 pauses mid-packet while requester 3 waits
    bus.req_tvalid = 4'b0010;
    bus.req_tlast = '0;
    bus.req_tdata[1*128 +: 128] = 128'hD0;
    bus.req_tdata[3*128 +: 128] = 128'hE;
    bus.req_tdest[3*4 +: 4] = 4'hB;
    #1;
    chk("hold_bubble", bus.axis_tvalid, 0);
    @(negedge clk);
    bus.req_tvalid = 4'b1010;
    bus.req_tlast = 4'b1000;
    #1;
    chk("hold_grant", grant_idx, 1);
    chk("hold_tdata0", bus.axis_tdata, 128'hD0);
    chk("hold_tready0", bus.req_tready, 4'b0010);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.req_tvalid = 4'b1000;
      #1;
      chk("hold_gap_tvalid", bus.axis_tvalid, 0);
      chk("hold_gap_tready", bus.req_tready, 4'b0010);
      chk("hold_gap_busy", busy, 1);
      @(negedge clk);
    end
    bus.req_tvalid = 4'b1010;
    bus.req_tlast = 4'b1010;
    bus.req_tdata[1*128 +: 128] = 128'hD1;
    #1;
    chk("hold_last_tvalid", bus.axis_tvalid, 1);
    chk("hold_last_tlast", bus.axis_tlast, 1);
    chk("hold_last_tdata", bus.axis_tdata, 128'hD1);
    chk("hold_last_grant", grant_idx, 1);
    @(negedge clk);
    bus.req_tvalid = 4'b1000;
    #1;
    chk("hold_after_tvalid", bus.axis_tvalid, 0);
    chk("hold_after_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("tag_grant", grant_idx, 3);
    chk("tag_tid", bus.axis_tid, 3);
    chk("tag_tdest", bus.axis_tdest, 4'hB);
    chk("tag_tuser", bus.axis_tuser, 0);
    chk("tag_tstrb", bus.axis_tstrb, 0);
    chk("tag_tkeep", bus.axis_tkeep, 0);
    chk("tag_tvalid", bus.axis_tvalid, 1);
    chk("tag_tdata", bus.axis_tdata, 128'hE);
    chk("tag_tready", bus.req_tready, 4'b1000);
    @(negedge clk);
    bus.req_tvalid = '0;
    #1;
    chk("tag_done_busy", busy, 0);
`ifdef AXIS_ARB_PKT_CNT_EN
    chk("cnt_pkt_all", pkt_count, 64'h0002_0002_0002_0002);
    chk("cnt_beat_all", beat_count, 16);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_tvalid", bus.axis_tvalid, 0);
`ifdef AXIS_ARB_PKT_CNT_EN
    chk("rst2_pkt", pkt_count, 0);
    chk("rst2_beat", beat_count, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    // three 2-beat packets from requester 0, then reset lands mid-beat
    for (int k = 0; k < 11; k++) begin
      ph = k % 3;
      bus.req_tvalid = 4'b0001;
      bus.req_tlast = ph == 2 ? 4'b0001 : 4'b0000;
      bus.req_tdata[0 +: 128] = 128'(256 + k);
      #1;
      if (ph == 0) chk("solo_bubble", bus.axis_tvalid, 0);
      else begin
        chk("solo_tvalid", bus.axis_tvalid, 1);
        chk("solo_tdata", bus.axis_tdata, 128'(256 + k));
      end
`ifdef AXIS_ARB_PKT_CNT_EN
      if (k == 9) begin
        chk("cnt_pkt0", pkt_count, 3);
        chk("cnt_beat", beat_count, 6);
      end
`endif
      if (k == 10) begin
        #2;
        rst = 1'b0;
        #1;
        chk("async_tvalid", bus.axis_tvalid, 0);
        chk("async_busy", busy, 0);
        chk("async_tready", bus.req_tready, 0);
        chk("async_grant", grant_idx, 0);
`ifdef AXIS_ARB_PKT_CNT_EN
        chk("async_pkt", pkt_count, 0);
        chk("async_beat", beat_count, 0);
`endif
      end
      @(negedge clk);
    end
    rst = 1'b1;
    bus.req_tvalid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
